// File: rtl/mem_access_unit.sv
// Memory-stage engine: issues a req/ack data-memory transaction for loads and stores, steers
// byte lanes, sign-extends loads, flags misaligned accesses and times out hung accesses.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] read_data2_in,
   input  logic [31:0] pc_in,
   input  logic [4:0]  regdst_in,
   input  logic        regwrite_in,
   input  logic        memwrite_in,
   input  logic        memread_in,
   input  logic [1:0]  memtoreg_in,
   input  logic [1:0]  decodeop_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic [31:0] wb_alu_result,
   output logic [31:0] wb_mem_data,
   output logic [31:0] wb_pc,
   output logic [4:0]  wb_regdst,
   output logic        wb_regwrite,
   output logic [1:0]  wb_memtoreg,
   output logic        misalign_err,
   output logic        bus_error
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
   logic            we_q, we_d;
   logic [3:0]      be_q, be_d;
   logic [1:0]      size_q, size_d, off_q, off_d;
   logic            misalign_q, misalign_d, bus_error_q, bus_error_d;
   logic [31:0]     wb_alu_q, wb_alu_d, wb_mem_q, wb_mem_d, wb_pc_q, wb_pc_d;
   logic [4:0]      wb_regdst_q, wb_regdst_d;
   logic            wb_regwrite_q, wb_regwrite_d;
   logic [1:0]      wb_memtoreg_q, wb_memtoreg_d;

   logic        mem_op, misaligned, last_cycle;
   logic [31:0] st_wdata, ld_data;
   logic [3:0]  st_be;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign mem_op     = memread_in | memwrite_in;
   assign last_cycle = (cnt_q == CntLast);

   always_comb begin
      st_wdata   = read_data2_in;
      st_be      = 4'b1111;
      misaligned = |alu_result_in[1:0];
      case (decodeop_in)
         2'b01: begin
            st_wdata   = {2{read_data2_in[15:0]}};
            st_be      = alu_result_in[1] ? 4'b1100 : 4'b0011;
            misaligned = alu_result_in[0];
         end
         2'b10: begin
            st_wdata   = {4{read_data2_in[7:0]}};
            st_be      = 4'b0001 << alu_result_in[1:0];
            misaligned = 1'b0;
         end
         default: ;
      endcase
   end

   // Load lane selection relies on the captured offset being aligned to the access size.
   assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
   assign ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      case (size_q)
         2'b01:   ld_data = {{16{ld_half[15]}}, ld_half};
         2'b10:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      if (reset) begin
         stall = (state_q == StIdle) ? (mem_op && !misaligned) : (!mem_ack && !last_cycle);
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      be_d          = be_q;
      size_d        = size_q;
      off_d         = off_q;
      misalign_d    = 1'b0;
      bus_error_d   = 1'b0;
      // MEM/WB defaults to a bubble; only retiring instructions overwrite it.
      wb_alu_d      = '0;
      wb_mem_d      = '0;
      wb_pc_d       = '0;
      wb_regdst_d   = '0;
      wb_regwrite_d = 1'b0;
      wb_memtoreg_d = '0;
      unique case (state_q)
         StIdle: begin
            if (!mem_op) begin
               wb_alu_d      = alu_result_in;
               wb_pc_d       = pc_in;
               wb_regdst_d   = regdst_in;
               wb_regwrite_d = regwrite_in;
               wb_memtoreg_d = memtoreg_in;
            end else if (misaligned) begin
               misalign_d = 1'b1;
            end else begin
               addr_d  = {alu_result_in[31:2], 2'b00};
               wdata_d = st_wdata;
               we_d    = memwrite_in;
               be_d    = st_be;
               size_d  = decodeop_in;
               off_d   = alu_result_in[1:0];
               cnt_d   = '0;
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (mem_ack) begin
               wb_alu_d      = alu_result_in;
               wb_mem_d      = we_q ? 32'd0 : ld_data;
               wb_pc_d       = pc_in;
               wb_regdst_d   = regdst_in;
               wb_regwrite_d = regwrite_in;
               wb_memtoreg_d = memtoreg_in;
               cnt_d         = '0;
               state_d       = StIdle;
            end else if (last_cycle) begin
               bus_error_d = 1'b1;
               cnt_d       = '0;
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         we_q          <= 1'b0;
         be_q          <= '0;
         size_q        <= '0;
         off_q         <= '0;
         misalign_q    <= 1'b0;
         bus_error_q   <= 1'b0;
         wb_alu_q      <= '0;
         wb_mem_q      <= '0;
         wb_pc_q       <= '0;
         wb_regdst_q   <= '0;
         wb_regwrite_q <= 1'b0;
         wb_memtoreg_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         we_q          <= we_d;
         be_q          <= be_d;
         size_q        <= size_d;
         off_q         <= off_d;
         misalign_q    <= misalign_d;
         bus_error_q   <= bus_error_d;
         wb_alu_q      <= wb_alu_d;
         wb_mem_q      <= wb_mem_d;
         wb_pc_q       <= wb_pc_d;
         wb_regdst_q   <= wb_regdst_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_memtoreg_q <= wb_memtoreg_d;
      end
   end

   assign mem_req       = (state_q == StAccess);
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_be        = be_q;
   assign misalign_err  = misalign_q;
   assign bus_error     = bus_error_q;
   assign wb_alu_result = wb_alu_q;
   assign wb_mem_data   = wb_mem_q;
   assign wb_pc         = wb_pc_q;
   assign wb_regdst     = wb_regdst_q;
   assign wb_regwrite   = wb_regwrite_q;
   assign wb_memtoreg   = wb_memtoreg_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-addressed reference model, randomized memory
// latency responder, and a monitor that checks every retired MEM/WB result.
module tb_mem_access_unit;

   localparam int unsigned T = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] alu_result_in = '0, read_data2_in = '0, pc_in = '0;
   logic [4:0]  regdst_in = '0;
   logic        regwrite_in = 1'b0, memwrite_in = 1'b0, memread_in = 1'b0;
   logic [1:0]  memtoreg_in = '0, decodeop_in = '0;
   logic        mem_req, mem_we, stall, misalign_err, bus_error;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] wb_alu_result, wb_mem_data, wb_pc;
   logic [4:0]  wb_regdst;
   logic        wb_regwrite;
   logic [1:0]  wb_memtoreg;

   mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .alu_result_in(alu_result_in), .read_data2_in(read_data2_in), .pc_in(pc_in),
      .regdst_in(regdst_in), .regwrite_in(regwrite_in), .memwrite_in(memwrite_in),
      .memread_in(memread_in), .memtoreg_in(memtoreg_in), .decodeop_in(decodeop_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
      .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_pc(wb_pc),
      .wb_regdst(wb_regdst), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
      .misalign_err(misalign_err), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu, mdata, pc;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  m2r;
      logic        mis, berr;
   } wb_t;

   typedef struct {
      logic [31:0] addr, wdata;
      logic        we;
      logic [3:0]  be;
      int          lat, len;
   } bus_t;

   wb_t        wb_q[$];
   bus_t       bus_q[$];
   logic [7:0] ref_mem[int];
   logic [7:0] bus_mem[int];
   int         checks = 0, failures = 0;
   bit         sb_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int a);
      logic [31:0] p;
      p = 32'(a) * 32'h9E37_79B1;
      return p[31:24];
   endfunction

   function automatic logic [7:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] bus_rd(input int a);
      return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
   endfunction

   // Reference model plus EX/MEM driver: holds the instruction until it retires.
   task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic [1:0] m2r, input logic [1:0] dop, input int lat);
      int   n, exp_stall, sc;
      bit   mis;
      wb_t  e;
      bus_t b;
      logic [31:0] v;
      n         = (dop == 2'b10) ? 1 : (dop == 2'b01) ? 2 : 4;
      mis       = (mr || mw) && (addr % n != 0);
      exp_stall = 0;
      e = '{alu: addr, mdata: 32'd0, pc: pc, rd: rd, rw: rw, m2r: m2r, mis: 1'b0, berr: 1'b0};
      if (mr || mw) begin
         e = '{alu: 32'd0, mdata: 32'd0, pc: 32'd0, rd: 5'd0, rw: 1'b0, m2r: 2'd0,
               mis: mis, berr: 1'b0};
         if (!mis) begin
            b.addr = addr & ~32'd3;
            b.we   = mw;
            b.lat  = lat;
            b.len  = (lat <= int'(T)) ? lat : int'(T);
            for (int i = 0; i < 4; i++) begin
               b.be[i]              = (b.addr + 32'(i) >= addr) && (b.addr + 32'(i) < addr + 32'(n));
               b.wdata[8*i +: 8]    = wd[8*(i % n) +: 8];
            end
            bus_q.push_back(b);
            exp_stall = b.len;
            if (lat <= int'(T)) begin
               e = '{alu: addr, mdata: 32'd0, pc: pc, rd: rd, rw: rw, m2r: m2r,
                     mis: 1'b0, berr: 1'b0};
               if (mw) begin
                  for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
               end else begin
                  v = '0;
                  for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(int'(addr) + k);
                  if (n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                  e.mdata = v;
               end
            end else begin
               e.berr = 1'b1;
            end
         end
      end
      wb_q.push_back(e);
      alu_result_in = addr; read_data2_in = wd; pc_in = pc; regdst_in = rd;
      regwrite_in = rw; memread_in = mr; memwrite_in = mw; memtoreg_in = m2r; decodeop_in = dop;
      sc = 0;
      forever begin
         @(negedge clk);
         if (!stall) break;
         sc++;
         if (sc > 200) begin
            chk("retire_timeout", 64'(sc), 64'(exp_stall));
            break;
         end
      end
      chk("stall_cycles", 64'(sc), 64'(exp_stall));
      @(posedge clk);
      #1;
      alu_result_in = '0; read_data2_in = '0; pc_in = '0; regdst_in = '0; regwrite_in = 1'b0;
      memread_in = 1'b0; memwrite_in = 1'b0; memtoreg_in = '0; decodeop_in = '0;
   endtask

   // Monitor: every edge that finds stall low retires one instruction into MEM/WB.
   wb_t mon_e;
   bit  cons = 1'b0;
   always @(negedge clk) begin
      if (sb_en && cons) begin
         if (wb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_retire actual=1 required=0");
         end else begin
            mon_e = wb_q.pop_front();
            chk("wb_alu_result", 64'(wb_alu_result), 64'(mon_e.alu));
            chk("wb_mem_data", 64'(wb_mem_data), 64'(mon_e.mdata));
            chk("wb_pc", 64'(wb_pc), 64'(mon_e.pc));
            chk("wb_ctrl", 64'({wb_regdst, wb_regwrite, wb_memtoreg}),
                64'({mon_e.rd, mon_e.rw, mon_e.m2r}));
            chk("misalign_err", 64'(misalign_err), 64'(mon_e.mis));
            chk("bus_error", 64'(bus_error), 64'(mon_e.berr));
         end
      end
      cons = sb_en && reset && !stall;
   end

   // Memory responder: checks the request fields and acks after the chosen latency.
   bus_t cur;
   bit   have = 1'b0;
   int   rcnt = 0;
   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         if (rcnt == 0) begin
            have = 1'b0;
            if (sb_en) begin
               if (bus_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_req actual=1 required=0");
               end else begin
                  cur  = bus_q.pop_front();
                  have = 1'b1;
               end
            end
         end
         rcnt++;
         if (have) begin
            chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
            chk("mem_we_be", 64'({mem_we, mem_be}), 64'({cur.we, cur.be}));
            chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
         end
         if (have && rcnt == cur.lat) begin
            mem_ack = 1'b1;
            for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = bus_rd(int'(mem_addr) + i);
            if (mem_we) begin
               for (int i = 0; i < 4; i++)
                  if (mem_be[i]) bus_mem[int'(mem_addr) + i] = mem_wdata[8*i +: 8];
            end
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end
      end else begin
         if (rcnt > 0 && have) chk("req_length", 64'(rcnt), 64'(cur.len));
         rcnt      = 0;
         have      = 1'b0;
         mem_ack   = sb_en && ($urandom_range(0, 5) == 0);
         mem_rdata = $urandom;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  dop;
      logic        mr, mw;
      int          n, kind, lat;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus_ctrl", 64'({mem_req, mem_we, mem_be, stall, misalign_err, bus_error}), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_wb_data", {wb_alu_result, wb_mem_data}, 64'd0);
      chk("rst_wb_ctrl", 64'({wb_pc, wb_regdst, wb_regwrite, wb_memtoreg}), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      sb_en = 1'b1;

      ref_mem[256] = 8'h00; ref_mem[257] = 8'h00; ref_mem[258] = 8'hFF; ref_mem[259] = 8'h80;
      bus_mem[256] = 8'h00; bus_mem[257] = 8'h00; bus_mem[258] = 8'hFF; bus_mem[259] = 8'h80;

      issue(32'h1234, 32'h0, 32'h4, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1);
      issue(32'h103, 32'h0, 32'h8, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 2'b10, 4);
      issue(32'h202, 32'h1234_ABCD, 32'hC, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b01, 2);
      issue(32'h202, 32'h0, 32'h10, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 2'b01, 1);
      issue(32'h301, 32'h0, 32'h14, 5'd3, 1'b1, 1'b1, 1'b0, 2'd1, 2'b00, 1);
      issue(32'h203, 32'h0, 32'h18, 5'd3, 1'b1, 1'b1, 1'b0, 2'd1, 2'b01, 1);
      issue(32'h300, 32'h0, 32'h1C, 5'd4, 1'b1, 1'b1, 1'b0, 2'd1, 2'b00, T + 1);
      issue(32'h300, 32'h0, 32'h20, 5'd4, 1'b1, 1'b1, 1'b0, 2'd1, 2'b00, T);
      issue(32'h304, 32'hDEAD_BEEF, 32'h24, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b11, 1);
      issue(32'h306, 32'h0000_0071, 32'h28, 5'd2, 1'b1, 1'b1, 1'b1, 2'd0, 2'b10, 2);
      issue(32'h304, 32'h0, 32'h2C, 5'd6, 1'b1, 1'b1, 1'b0, 2'd1, 2'b00, 1);

      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 5);
         dop  = 2'($urandom_range(0, 3));
         n    = (dop == 2'b10) ? 1 : (dop == 2'b01) ? 2 : 4;
         a    = 32'h1000 + 32'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
         lat  = ($urandom_range(0, 9) == 0) ? int'(T) + 1 : int'($urandom_range(1, 5));
         if ($urandom_range(0, 19) == 0) lat = int'(T);
         mr   = (kind == 1 || kind == 2 || kind == 5);
         mw   = (kind == 3 || kind == 4 || kind == 5);
         issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom), mr, mw, 2'($urandom), dop, lat);
      end

      @(negedge clk);
      #1;
      sb_en = 1'b0;
      chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
      chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);

      // Reset in the middle of an access that is never acknowledged.
      @(posedge clk);
      #1;
      alu_result_in = 32'h400; memread_in = 1'b1; regwrite_in = 1'b1; decodeop_in = 2'b00;
      pc_in = 32'h44; regdst_in = 5'd8;
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("pre_reset_req", 64'({mem_req, stall}), 64'b11);
      reset = 1'b0;
      #1;
      chk("async_reset_req_stall", 64'({mem_req, stall}), 64'd0);
      chk("async_reset_addr", 64'(mem_addr), 64'd0);
      chk("async_reset_wb", {wb_alu_result, wb_pc}, 64'd0);
      alu_result_in = '0; memread_in = 1'b0; regwrite_in = 1'b0; pc_in = '0; regdst_in = '0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("post_reset_idle", 64'({mem_req, stall, bus_error, misalign_err}), 64'd0);
         chk("post_reset_wb", 64'({wb_mem_data, wb_regdst, wb_regwrite, wb_memtoreg}), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
